// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 16-bit ALU between two requesters.
// Round-robin (or fixed-priority) arbitration. The winner's operands are
// captured and run through the ALU for one cycle. The result is returned
// registered and tagged with the requester id. The N/V/Z flag register
// changes only on CMP.
// Optional macro ALU_ARB_OVERLAP_EN: grant a new request in the same cycle
// that the response is accepted, giving back-to-back ops every 2 cycles.

// Combinational 16-bit ALU: 00 ADD, 01 CMP (subtract), 10 AND, 11 MVN.
module alu_share_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] y,
  output logic [2:0]        st    // {N,V,Z}
);
  logic [DATA_W-1:0] diff;
  logic              ovf;

  // Subtraction overflow occurs when the operand signs differ and the
  // result sign differs from a.
  always_comb begin
    diff = a - b;
    ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    y    = '0;
    unique case (op)
      2'b00:   y = a + b;
      2'b01:   y = diff;
      2'b10:   y = a & b;
      default: y = ~b;
    endcase
    st = {diff[DATA_W-1], ovf, (diff == '0)};
  end
endmodule

module alu_share_arbiter #(
  parameter int DATA_W     = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_ain,
  input  logic [DATA_W-1:0] req0_bin,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_ain,
  input  logic [DATA_W-1:0] req1_bin,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic [2:0]        rsp_status,
  output logic [2:0]        flags,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [1:0] OP_CMP = 2'b01;

`ifdef ALU_ARB_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  state_t            state, state_d;
  logic              rr_ptr;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        op_q;
  logic              id_q;
  logic              can_grant, g0, g1, grant;
  logic [DATA_W-1:0] alu_y;
  logic [2:0]        alu_st;

  // Arbitration: port 0 wins when it is alone, when priority is fixed,
  // or when the pointer favors it. Port 1 takes whatever port 0 does not.
  always_comb begin
    can_grant  = (state == IDLE) || (OVERLAP && state == RESP && rsp_ready);
    g0         = req0_valid && (!req1_valid || FIXED_PRIO || !rr_ptr);
    g1         = req1_valid && !g0;
    req0_ready = can_grant && g0;
    req1_ready = can_grant && g1;
    grant      = req0_ready || req1_ready;
  end

  // Next-state logic. EXEC always lasts one cycle.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  alu_share_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y),
    .st (alu_st)
  );

  // Operand capture on grant, the result register, and the flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_status <= '0;
      flags      <= '0;
    end else begin
      if (grant) begin
        a_q    <= req1_ready ? req1_ain : req0_ain;
        b_q    <= req1_ready ? req1_bin : req0_bin;
        op_q   <= req1_ready ? req1_op  : req0_op;
        id_q   <= req1_ready;
        rr_ptr <= !req1_ready;  // point at the port that lost
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        if (op_q == OP_CMP) begin
          rsp_out    <= '0;
          rsp_status <= alu_st;
          flags      <= alu_st;
        end else begin
          rsp_out    <= alu_y;
          rsp_status <= flags;
        end
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table plus hand-written
// sequences for backpressure, mid-operation reset and contention.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, rsp_ready = 1'b1;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;

  logic        rdy0, rdy1, rsp_valid, rsp_id, busy;
  logic [15:0] rsp_out;
  logic [2:0]  rsp_status, flags;
  logic        f_rdy0, f_rdy1, f_valid, f_id, f_busy;
  logic [15:0] f_out;
  logic [2:0]  f_status, f_flags;

  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(16), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0), .req0_ain(a0), .req0_bin(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_ain(a1), .req1_bin(b1), .req1_op(op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_status(rsp_status), .flags(flags), .busy(busy));

  alu_share_arbiter #(.DATA_W(16), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(f_rdy0), .req0_ain(a0), .req0_bin(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(f_rdy1), .req1_ain(a1), .req1_bin(b1), .req1_op(op1),
    .rsp_valid(f_valid), .rsp_ready(rsp_ready), .rsp_id(f_id), .rsp_out(f_out),
    .rsp_status(f_status), .flags(f_flags), .busy(f_busy));

  typedef struct {
    logic        port;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [2:0]  exp_status;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs[10];

`ifdef ALU_ARB_OVERLAP_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One request through the whole flow with rsp_ready held high.
  task automatic run_vec(input vec_t v, input int idx);
    bit hs = 0;
    if (v.port) begin a1 = v.a; b1 = v.b; op1 = v.op; v1 = 1'b1; end
    else        begin a0 = v.a; b0 = v.b; op0 = v.op; v0 = 1'b1; end
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      if (v.port ? rdy1 : rdy0) hs = 1;
    end
    check($sformatf("v%0d_grant", idx), hs, 1);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    if (!hs) return;
    @(negedge clk);
    check($sformatf("v%0d_exec_valid", idx), rsp_valid, 0);
    @(negedge clk);
    check($sformatf("v%0d_valid", idx), rsp_valid, 1);
    check($sformatf("v%0d_out", idx), rsp_out, v.exp_out);
    check($sformatf("v%0d_id", idx), rsp_id, v.port);
    check($sformatf("v%0d_status", idx), rsp_status, v.exp_status);
    check($sformatf("v%0d_flags", idx), flags, v.exp_flags);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, n1, dbl, c0_last, c1_last;
    bit hs;

    //               port op     a         b         out       status  flags
    vecs[0] = '{1'b0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 3'b000, 3'b000};
    vecs[1] = '{1'b1, 2'b01, 16'h0005, 16'h0005, 16'h0000, 3'b001, 3'b001};
    vecs[2] = '{1'b1, 2'b00, 16'h0001, 16'h0001, 16'h0002, 3'b001, 3'b001};
    vecs[3] = '{1'b0, 2'b01, 16'h8000, 16'h0001, 16'h0000, 3'b010, 3'b010};
    vecs[4] = '{1'b0, 2'b01, 16'h0001, 16'h0002, 16'h0000, 3'b100, 3'b100};
    vecs[5] = '{1'b0, 2'b10, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b100, 3'b100};
    vecs[6] = '{1'b1, 2'b11, 16'h1234, 16'h00FF, 16'hFF00, 3'b100, 3'b100};
    vecs[7] = '{1'b1, 2'b00, 16'hFFFF, 16'h0002, 16'h0001, 3'b100, 3'b100};
    vecs[8] = '{1'b0, 2'b01, 16'h0000, 16'h0000, 16'h0000, 3'b001, 3'b001};
    vecs[9] = '{1'b1, 2'b01, 16'h7FFF, 16'hFFFF, 16'h0000, 3'b110, 3'b110};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_out", rsp_out, 0);
    check("rst_status", rsp_status, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {rdy0, rdy1}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: hold the response for 5 cycles while port 1 waits.
    rsp_ready = 1'b0;
    a0 = 16'd3; b0 = 16'd4; op0 = 2'b00; v0 = 1'b1;
    hs = 0;
    for (int k = 0; k < 20 && !hs; k++) begin @(negedge clk); if (rdy0) hs = 1; end
    check("bp_grant0", hs, 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    a1 = 16'd10; b1 = 16'd20; op1 = 2'b00; v1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), rsp_valid, 1);
      check($sformatf("bp%0d_out", i), rsp_out, 16'd7);
      check($sformatf("bp%0d_id", i), rsp_id, 0);
      check($sformatf("bp%0d_busy", i), busy, 1);
      check($sformatf("bp%0d_ready", i), {rdy0, rdy1}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", rsp_valid, 1);
    check("bp_rel_rdy1", rdy1, OVERLAP_EXP());
    @(negedge clk);
    check("bp_drop_valid", rsp_valid, 0);
`ifndef ALU_ARB_OVERLAP_EN
    check("bp_idle_rdy1", rdy1, 1);
`endif
    @(posedge clk); #1;
`ifdef ALU_ARB_OVERLAP_EN
    @(posedge clk); #1;
`endif
    v1 = 1'b0;
    hs = 0;
    for (int k = 0; k < 10 && !hs; k++) begin @(negedge clk); if (rsp_valid) hs = 1; end
    check("bp_p1_valid", hs, 1);
    check("bp_p1_id", rsp_id, 1);
    check("bp_p1_out", rsp_out, 16'd30);
    check("bp_p1_status", rsp_status, 3'b110);
    @(posedge clk); #1;

    // Reset during EXEC of a CMP.
    a0 = 16'd5; b0 = 16'd6; op0 = 2'b01; v0 = 1'b1;
    hs = 0;
    for (int k = 0; k < 20 && !hs; k++) begin @(negedge clk); if (rdy0) hs = 1; end
    check("mr_grant", hs, 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    check("mr_pre_flags", flags, 3'b110);
    check("mr_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", rsp_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_flags", flags, 0);
    check("mr_out", rsp_out, 0);
    check("mr_status", rsp_status, 0);
    check("mr_id", rsp_id, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec('{1'b0, 2'b00, 16'd2, 16'd3, 16'd5, 3'b000, 3'b000}, 10);

    // Contention: both ports continuously valid, fresh from reset.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    a0 = 16'd1; b0 = 16'd1; op0 = 2'b00;
    a1 = 16'd2; b1 = 16'd2; op1 = 2'b00;
    v0 = 1'b1; v1 = 1'b1;
    n0 = 0; n1 = 0; dbl = 0; c0_last = -1; c1_last = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((rdy0 && rdy1) || (f_rdy0 && f_rdy1)) dbl++;
      if (rsp_valid && n0 < 6) begin
        check($sformatf("rr%0d_id", n0), rsp_id, n0 % 2);
        if (c0_last >= 0) check($sformatf("rr%0d_spacing", n0), c - c0_last, SPACING);
        c0_last = c;
        n0++;
      end
      if (f_valid && n1 < 6) begin
        check($sformatf("fp%0d_id", n1), f_id, 0);
        if (c1_last >= 0) check($sformatf("fp%0d_spacing", n1), c - c1_last, SPACING);
        c1_last = c;
        n1++;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    check("rr_count", n0, 6);
    check("fp_count", n1, 6);
    check("no_double_ready", dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic OVERLAP_EXP();
`ifdef ALU_ARB_OVERLAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction
endmodule
